b_fetch_unit: RTL and testbench

//  Read-side partner of b_memory: instruction fetch engine between the program counter and decode.

---
 rtl/b_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_b_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_fetch_unit.sv
// Instruction fetch engine: credit-limited sequential reads into a fixed-latency memory, buffered in a
// small FIFO toward decode; redirect flushes and restarts. Optional FETCH_CNT_EN adds an accepted-fetch counter.
module b_fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      MEM_LAT  = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             Rnot_i,
    input  logic             en_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             mem_req_o,
    output logic [WIDTH-1:0] mem_addr_o,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [WIDTH-1:0] inst_o,
`ifdef FETCH_CNT_EN
    output logic [31:0]      fetch_count_o,
`endif
    output logic [WIDTH-1:0] inst_pc_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e                        state_q, state_d;
    logic [WIDTH-1:0]              pc_q, pc_d;
    logic [DEPTH-1:0][WIDTH-1:0]   fdat_q, fdat_d, fpc_q, fpc_d;
    logic [AW-1:0]                 rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]                   cnt_q, cnt_d;
    logic [MEM_LAT-1:0]            vld_pipe_q, vld_pipe_d, keep_q, keep_d;
    logic [MEM_LAT-1:0][WIDTH-1:0] ppc_q, ppc_d;
    logic [31:0]                   inflight;
    logic                          issue, resp, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) inflight = inflight + 32'(vld_pipe_q[i]);
    end

    // Credit counts queued plus in-flight words so every returning word is guaranteed a FIFO slot.
    assign issue = Rnot_i && (state_q == FETCH) && en_i && !redirect_i &&
                   ((32'(cnt_q) + inflight) < 32'(DEPTH));
    assign resp  = vld_pipe_q[MEM_LAT-1] & keep_q[MEM_LAT-1] & ~redirect_i;

    assign mem_req_o    = issue;
    assign mem_addr_o   = pc_q;
    assign inst_valid_o = (cnt_q != '0) & ~redirect_i;
    assign pop          = inst_valid_o & inst_ready_i;
    assign inst_o       = fdat_q[rd_q];
    assign inst_pc_o    = fpc_q[rd_q];

    // Entries in flight across a redirect keep their valid bit (so DRAIN can count them) but lose keep.
    always_comb begin
        vld_pipe_d    = '0;
        keep_d        = '0;
        ppc_d         = '0;
        vld_pipe_d[0] = issue;
        keep_d[0]     = 1'b1;
        ppc_d[0]      = pc_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            keep_d[i]     = keep_q[i-1] & ~redirect_i;
            ppc_d[i]      = ppc_q[i-1];
        end
    end

    always_comb begin
        fdat_d = fdat_q;
        fpc_d  = fpc_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        if (redirect_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (resp) begin
                fdat_d[wr_q] = mem_rdata_i;
                fpc_d[wr_q]  = ppc_q[MEM_LAT-1];
                wr_d         = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + {{AW{1'b0}}, resp} - {{AW{1'b0}}, pop};
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i & {{(WIDTH-2){1'b1}}, 2'b00};
                    if (|vld_pipe_d) state_d = DRAIN;
                end else if (issue) begin
                    pc_d = pc_q + WIDTH'(4);
                end
            end
            DRAIN: begin
                if (redirect_i) pc_d = redirect_pc_i & {{(WIDTH-2){1'b1}}, 2'b00};
                else if (inflight == '0) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge Rnot_i) begin
        if (!Rnot_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            fdat_q     <= '0;
            fpc_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            keep_q     <= '0;
            ppc_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fdat_q     <= fdat_d;
            fpc_q      <= fpc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            keep_q     <= keep_d;
            ppc_q      <= ppc_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fcnt_q;
    always_ff @(posedge clk_i or negedge Rnot_i) begin
        if (!Rnot_i) fcnt_q <= '0;
        else         fcnt_q <= fcnt_q + 32'(pop);
    end
    assign fetch_count_o = fcnt_q;
`else
    // Counter omitted in this build.
`endif

endmodule

// File: tb/tb_b_fetch_unit.sv
// Bench for b_fetch_unit: directed vector table, hand sequences for redirect/reset/wrap, and a randomized
// run against a stream-level reference model (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_b_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en1, rd1, req1, iv1, rdy1;
    logic [31:0] rpc1, addr1, rdata1, inst1, ipc1;
    logic        en3, rd3, req3, iv3, rdy3;
    logic [31:0] rpc3, addr3, rdata3, inst3, ipc3;
`ifdef FETCH_CNT_EN
    logic [31:0] fc1, fc3;
`endif

    b_fetch_unit #(.WIDTH(32), .DEPTH(4), .MEM_LAT(1), .RESET_PC(32'h0)) u1 (
        .clk_i(clk), .Rnot_i(rst_n), .en_i(en1), .redirect_i(rd1), .redirect_pc_i(rpc1),
        .mem_req_o(req1), .mem_addr_o(addr1), .mem_rdata_i(rdata1),
        .inst_valid_o(iv1), .inst_ready_i(rdy1), .inst_o(inst1),
`ifdef FETCH_CNT_EN
        .fetch_count_o(fc1),
`endif
        .inst_pc_o(ipc1));

    b_fetch_unit #(.WIDTH(32), .DEPTH(4), .MEM_LAT(3), .RESET_PC(32'h0)) u3 (
        .clk_i(clk), .Rnot_i(rst_n), .en_i(en3), .redirect_i(rd3), .redirect_pc_i(rpc3),
        .mem_req_o(req3), .mem_addr_o(addr3), .mem_rdata_i(rdata3),
        .inst_valid_o(iv3), .inst_ready_i(rdy3), .inst_o(inst3),
`ifdef FETCH_CNT_EN
        .fetch_count_o(fc3),
`endif
        .inst_pc_o(ipc3));

    // Memory models: word at addr reads as addr|0xA000, poison when no request was made.
    logic [31:0] m1;
    logic [31:0] m3 [3];
    always @(posedge clk) m1 <= req1 ? (addr1 | 32'hA000) : 32'hBAD0BAD0;
    always @(posedge clk) begin
        m3[0] <= req3 ? (addr3 | 32'hA000) : 32'hBAD0BAD0;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign rdata1 = m1;
    assign rdata3 = m3[2];

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en1 = 1'b1; rdy1 = 1'b1; rd1 = 1'b0; rpc1 = '0;
        en3 = 1'b1; rdy3 = 1'b1; rd3 = 1'b0; rpc3 = '0;
        tick();
        tick();
        @(negedge clk);
        chk("reset.req1", {31'b0, req1}, 32'd0);
        chk("reset.iv1", {31'b0, iv1}, 32'd0);
        chk("reset.addr1", addr1, 32'h0);
        chk("reset.inst1", inst1, 32'h0);
        chk("reset.ipc1", ipc1, 32'h0);
        chk("reset.req3", {31'b0, req3}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en1 = 1'b0; rdy1 = 1'b0; en3 = 1'b0; rdy3 = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] inst;
        logic [31:0] ipc;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(bit rst, bit en, bit rdy, bit req, logic [31:0] addr,
                                bit iv, logic [31:0] inst, logic [31:0] ipc);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.req = req;
        v.addr = addr; v.iv = iv; v.inst = inst; v.ipc = ipc;
        return v;
    endfunction

    // Stream-level reference: next issue address, next delivered pc, words owed to decode.
    logic [31:0] m_iss [2];
    logic [31:0] m_exp [2];
    int          m_out [2];
    int          m_pops[2];

    task automatic model_step(input int id, input logic redir, input logic [31:0] rpc, input logic rdy,
                              input logic req, input logic [31:0] addr, input logic iv,
                              input logic [31:0] inst, input logic [31:0] ipc);
        if (req) begin
            chk($sformatf("rnd%0d.addr", id), addr, m_iss[id]);
            m_iss[id] = m_iss[id] + 32'd4;
            m_out[id]++;
            chk($sformatf("rnd%0d.credit", id), {31'b0, m_out[id] <= 4}, 32'd1);
        end
        if (iv) begin
            chk($sformatf("rnd%0d.data", id), inst, ipc | 32'hA000);
            if (rdy) begin
                chk($sformatf("rnd%0d.pc", id), ipc, m_exp[id]);
                m_exp[id] = m_exp[id] + 32'd4;
                m_out[id]--;
                m_pops[id]++;
            end
        end
        if (redir) begin
            chk($sformatf("rnd%0d.redir_iv", id), {31'b0, iv}, 32'd0);
            chk($sformatf("rnd%0d.redir_req", id), {31'b0, req}, 32'd0);
            m_iss[id] = rpc & 32'hFFFF_FFFC;
            m_exp[id] = rpc & 32'hFFFF_FFFC;
            m_out[id] = 0;
        end
    endtask

    initial begin
        logic [31:0] e6_addr [3];
        logic [31:0] e6_pc [3];

        // Startup stream, then a 10-cycle stall that fills the FIFO and a drain that resumes at 0x10.
        vq.push_back(mk(1, 1, 1, 1, 32'h00, 0, 32'h0, 32'h0));
        vq.push_back(mk(0, 1, 1, 1, 32'h04, 0, 32'h0, 32'h0));
        vq.push_back(mk(0, 1, 1, 1, 32'h08, 1, 32'hA000, 32'h0));
        vq.push_back(mk(0, 1, 1, 1, 32'h0C, 1, 32'hA004, 32'h4));
        vq.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'hA008, 32'h8));
        vq.push_back(mk(1, 1, 0, 1, 32'h00, 0, 32'h0, 32'h0));
        vq.push_back(mk(0, 1, 0, 1, 32'h04, 0, 32'h0, 32'h0));
        vq.push_back(mk(0, 1, 0, 1, 32'h08, 1, 32'hA000, 32'h0));
        vq.push_back(mk(0, 1, 0, 1, 32'h0C, 1, 32'hA000, 32'h0));
        for (int i = 0; i < 6; i++) vq.push_back(mk(0, 1, 0, 0, 32'h10, 1, 32'hA000, 32'h0));
        vq.push_back(mk(0, 1, 1, 0, 32'h10, 1, 32'hA000, 32'h0));
        vq.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'hA004, 32'h4));
        vq.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'hA008, 32'h8));
        vq.push_back(mk(0, 1, 1, 1, 32'h18, 1, 32'hA00C, 32'hC));
        vq.push_back(mk(0, 1, 1, 1, 32'h1C, 1, 32'hA010, 32'h10));

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            en1 = vq[i].en;
            rdy1 = vq[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d.req", i), {31'b0, req1}, {31'b0, vq[i].req});
            chk($sformatf("vec%0d.addr", i), addr1, vq[i].addr);
            chk($sformatf("vec%0d.iv", i), {31'b0, iv1}, {31'b0, vq[i].iv});
            if (vq[i].iv) begin
                chk($sformatf("vec%0d.inst", i), inst1, vq[i].inst);
                chk($sformatf("vec%0d.ipc", i), ipc1, vq[i].ipc);
            end
            tick();
        end

        // Redirect with one read in flight and two queued; low address bits are dropped.
        do_reset();
        en1 = 1'b1; rdy1 = 1'b0;
        tick(); tick(); tick();
        rd1 = 1'b1; rpc1 = 32'h103;
        @(negedge clk);
        chk("redir.iv", {31'b0, iv1}, 32'd0);
        chk("redir.req", {31'b0, req1}, 32'd0);
        tick();
        rd1 = 1'b0; rdy1 = 1'b1;
        @(negedge clk);
        chk("redir.addr", addr1, 32'h100);
        chk("redir.req_after", {31'b0, req1}, 32'd1);
        chk("redir.no_stale", {31'b0, iv1}, 32'd0);
        tick(); tick();
        @(negedge clk);
        chk("redir.inst", inst1, 32'hA100);
        chk("redir.ipc", ipc1, 32'h100);

        // Redirect coinciding with ready while 0xA004 is at the head.
        do_reset();
        en1 = 1'b1; rdy1 = 1'b1;
        tick(); tick(); tick();
        rd1 = 1'b1; rpc1 = 32'h200;
        @(negedge clk);
        chk("redpop.iv", {31'b0, iv1}, 32'd0);
`ifdef FETCH_CNT_EN
        chk("redpop.count", fc1, 32'd1);
`endif
        tick();
        rd1 = 1'b0;
        @(negedge clk);
        chk("redpop.addr", addr1, 32'h200);
        tick(); tick();
        @(negedge clk);
        chk("redpop.inst", inst1, 32'hA200);
        chk("redpop.ipc", ipc1, 32'h200);
`ifdef FETCH_CNT_EN
        chk("redpop.count_hold", fc1, 32'd1);
`endif
        tick();

        // Asynchronous reset mid-stream with the FIFO full.
        do_reset();
        en1 = 1'b1; rdy1 = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("areset.full_iv", {31'b0, iv1}, 32'd1);
        chk("areset.full_req", {31'b0, req1}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.iv", {31'b0, iv1}, 32'd0);
        chk("areset.req", {31'b0, req1}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("areset.restart_req", {31'b0, req1}, 32'd1);
        chk("areset.restart_addr", addr1, 32'h0);
        chk("areset.restart_iv", {31'b0, iv1}, 32'd0);
        tick();
        @(negedge clk);
        chk("areset.next_addr", addr1, 32'h4);
        tick();

        // Address wrap with MEM_LAT=3.
        do_reset();
        en1 = 1'b0;
        rd3 = 1'b1; rpc3 = 32'hFFFF_FFFB;
        tick();
        rd3 = 1'b0; en3 = 1'b1; rdy3 = 1'b1;
        e6_addr[0] = 32'hFFFF_FFF8; e6_addr[1] = 32'hFFFF_FFFC; e6_addr[2] = 32'h0;
        e6_pc[0] = 32'hFFFF_FFF8; e6_pc[1] = 32'hFFFF_FFFC; e6_pc[2] = 32'h0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 3) begin
                chk($sformatf("wrap.req%0d", k), {31'b0, req3}, 32'd1);
                chk($sformatf("wrap.addr%0d", k), addr3, e6_addr[k]);
            end else if (k == 3) begin
                chk("wrap.iv3", {31'b0, iv3}, 32'd0);
            end else begin
                chk($sformatf("wrap.iv%0d", k), {31'b0, iv3}, 32'd1);
                chk($sformatf("wrap.ipc%0d", k), ipc3, e6_pc[k-4]);
                chk($sformatf("wrap.inst%0d", k), inst3, e6_pc[k-4] | 32'hA000);
            end
            tick();
        end

        // Randomized traffic on both instances against the stream model.
        do_reset();
        for (int id = 0; id < 2; id++) begin
            m_iss[id] = 32'h0; m_exp[id] = 32'h0; m_out[id] = 0; m_pops[id] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            en1  = ($urandom_range(0, 7) != 0);
            rdy1 = ($urandom_range(0, 3) != 0);
            rd1  = ($urandom_range(0, 39) == 0);
            rpc1 = $urandom;
            en3  = ($urandom_range(0, 7) != 0);
            rdy3 = ($urandom_range(0, 3) != 0);
            rd3  = ($urandom_range(0, 39) == 0);
            rpc3 = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
            @(negedge clk);
            model_step(0, rd1, rpc1, rdy1, req1, addr1, iv1, inst1, ipc1);
            model_step(1, rd3, rpc3, rdy3, req3, addr3, iv3, inst3, ipc3);
            tick();
        end
        chk("rnd0.progress", {31'b0, m_pops[0] > 200}, 32'd1);
        chk("rnd1.progress", {31'b0, m_pops[1] > 200}, 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
